// File: rtl/cpu_regfile_pkg.sv
// Shared definitions for the register-bank port sequencer: widths, FSM states,
// and the x0 read-gating helper.
package cpu_regfile_pkg;

  localparam int unsigned DATA_WIDTH     = 32;
  localparam int unsigned REG_ADDR_WIDTH = 4;

  // Architectural zero register index
  localparam logic [REG_ADDR_WIDTH-1:0] ZERO_REG = '0;

  // Sequencer states: one write slot, or three bank-port cycles plus a result cycle
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    RD1  = 3'd2,
    RD2  = 3'd3,
    RD3  = 3'd4,
    DONE = 3'd5
  } seq_state_t;

  // x0 always reads as zero, whatever the bank returns for index 0
  function automatic logic [DATA_WIDTH-1:0] x0_gate(
    input logic [REG_ADDR_WIDTH-1:0] idx,
    input logic [DATA_WIDTH-1:0]     data
  );
    return (idx == ZERO_REG) ? '0 : data;
  endfunction

endpackage

// File: rtl/register_port_sequencer_if.sv
// Bundle of the decode read channel, execute writeback channel, and the
// single-port register bank connection seen by the sequencer.
interface register_port_sequencer_if;
  import cpu_regfile_pkg::*;

  // Operand read request / response
  logic                      readValid;
  logic                      readReady;
  logic [REG_ADDR_WIDTH-1:0] rs1;
  logic [REG_ADDR_WIDTH-1:0] rs2;
  logic                      operandsValid;
  logic [DATA_WIDTH-1:0]     rs1Value;
  logic [DATA_WIDTH-1:0]     rs2Value;

  // Writeback request
  logic                      wbValid;
  logic                      wbReady;
  logic [REG_ADDR_WIDTH-1:0] wbReg;
  logic [DATA_WIDTH-1:0]     wbData;

  // Register bank port
  logic [REG_ADDR_WIDTH-1:0] bankRegNum;
  logic [DATA_WIDTH-1:0]     bankDataIn;
  logic                      bankWriteEnable;
  logic [DATA_WIDTH-1:0]     bankDataOut;

  // Sequencer side
  modport slave (
    input  readValid, rs1, rs2, wbValid, wbReg, wbData, bankDataOut,
    output readReady, operandsValid, rs1Value, rs2Value, wbReady,
           bankRegNum, bankDataIn, bankWriteEnable
  );

  // Requester / bank side
  modport master (
    output readValid, rs1, rs2, wbValid, wbReg, wbData, bankDataOut,
    input  readReady, operandsValid, rs1Value, rs2Value, wbReady,
           bankRegNum, bankDataIn, bankWriteEnable
  );

endinterface

// File: rtl/register_port_sequencer.sv
// Serializes operand reads and writebacks onto the single-port 16x32 register
// bank. Writeback wins over reads in IDLE; x0 reads return zero and x0 writes
// never reach the bank.
module register_port_sequencer #(
  parameter int unsigned DATA_WIDTH     = cpu_regfile_pkg::DATA_WIDTH,
  parameter int unsigned REG_ADDR_WIDTH = cpu_regfile_pkg::REG_ADDR_WIDTH
) (
  input logic                        clk,
  input logic                        reset,
  register_port_sequencer_if.slave   bus
);
  import cpu_regfile_pkg::*;

  seq_state_t                r_state;
  logic [REG_ADDR_WIDTH-1:0] r_rs1;
  logic [REG_ADDR_WIDTH-1:0] r_rs2;
  logic [DATA_WIDTH-1:0]     r_rs1_value;
  logic [DATA_WIDTH-1:0]     r_rs2_value;
  logic                      r_operands_valid;
  logic [REG_ADDR_WIDTH-1:0] r_bank_reg_num;
  logic [DATA_WIDTH-1:0]     r_bank_data_in;
  logic                      r_bank_we;

  logic w_idle;
  logic w_wb_accept;
  logic w_rd_accept;

  // Handshake decode: only IDLE accepts, and a pending writeback blocks reads
  assign w_idle      = (r_state == IDLE);
  assign w_wb_accept = w_idle && bus.wbValid;
  assign w_rd_accept = w_idle && bus.readValid && !bus.wbValid;

  // FSM with registered bank address/data/strobe and operand capture
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= IDLE;
      r_rs1            <= '0;
      r_rs2            <= '0;
      r_rs1_value      <= '0;
      r_rs2_value      <= '0;
      r_operands_valid <= 1'b0;
      r_bank_reg_num   <= '0;
      r_bank_data_in   <= '0;
      r_bank_we        <= 1'b0;
    end else begin
      // Bank port idles at zero and the result strobe is a single pulse
      r_operands_valid <= 1'b0;
      r_bank_reg_num   <= '0;
      r_bank_data_in   <= '0;
      r_bank_we        <= 1'b0;

      case (r_state)
        IDLE: begin
          if (w_wb_accept) begin
            r_bank_reg_num <= bus.wbReg;
            r_bank_data_in <= bus.wbData;
            r_bank_we      <= (bus.wbReg != REG_ADDR_WIDTH'(ZERO_REG));
            r_state        <= WR;
          end else if (w_rd_accept) begin
            r_rs1          <= bus.rs1;
            r_rs2          <= bus.rs2;
            r_bank_reg_num <= bus.rs1;
            r_state        <= RD1;
          end
        end
        WR: begin
          r_state <= IDLE;
        end
        RD1: begin
          r_bank_reg_num <= r_rs2;
          r_state        <= RD2;
        end
        RD2: begin
          // Bank output now reflects rs1 addressed during RD1
          r_rs1_value    <= x0_gate(r_rs1, bus.bankDataOut);
          r_bank_reg_num <= r_rs2;
          r_state        <= RD3;
        end
        RD3: begin
          // Bank output now reflects rs2 addressed during RD2
          r_rs2_value      <= x0_gate(r_rs2, bus.bankDataOut);
          r_operands_valid <= 1'b1;
          r_state          <= DONE;
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Ready signals follow the current request so the handshake closes in one edge
  assign bus.readReady       = w_rd_accept || (w_idle && !bus.wbValid);
  assign bus.wbReady         = w_idle;

  // Reset kills an in-flight write strobe immediately
  assign bus.bankWriteEnable = r_bank_we && !reset;

  assign bus.bankRegNum      = r_bank_reg_num;
  assign bus.bankDataIn      = r_bank_data_in;
  assign bus.operandsValid   = r_operands_valid;
  assign bus.rs1Value        = r_rs1_value;
  assign bus.rs2Value        = r_rs2_value;

endmodule

// File: tb/tb_register_port_sequencer.sv
// Directed bench for register_port_sequencer with a one-cycle registered
// 16x32 bank model attached to the bank port.
module tb_register_port_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic bank_init = 1'b1;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int we_count = 0;
  int accept_cyc = 0;

  logic [31:0] mem [16];
  logic [31:0] bank_q = 32'h0;

  register_port_sequencer_if bus ();

  register_port_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Bank model: write on the edge, read data registered from the address at that edge
  always @(posedge clk) begin
    if (bank_init) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'hA500_0000 | 32'(i);
    end else if (bus.bankWriteEnable) begin
      mem[bus.bankRegNum] <= bus.bankDataIn;
    end
    bank_q <= mem[bus.bankRegNum];
    if (bus.bankWriteEnable) we_count <= we_count + 1;
    cyc <= cyc + 1;
  end

  assign bus.bankDataOut = bank_q;

  // Global time limit
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one writeback; checks the WR cycle and the bank strobe count
  task automatic do_write(input logic [3:0] rd, input logic [31:0] d, input string tag);
    int waited = 0;
    int we0;
    bus.wbValid = 1'b1;
    bus.wbReg   = rd;
    bus.wbData  = d;
    while (!bus.wbReady && waited < 20) begin
      tick();
      waited++;
    end
    check({tag, "_wbready"}, 32'(bus.wbReady), 32'd1);
    tick();
    bus.wbValid = 1'b0;
    we0 = we_count;
    check({tag, "_we"},      32'(bus.bankWriteEnable), (rd != 4'd0) ? 32'd1 : 32'd0);
    check({tag, "_regnum"},  32'(bus.bankRegNum), 32'(rd));
    check({tag, "_datain"},  bus.bankDataIn, d);
    check({tag, "_wr_wbr"},  32'(bus.wbReady), 32'd0);
    check({tag, "_wr_rdr"},  32'(bus.readReady), 32'd0);
    tick();
    check({tag, "_wecount"}, 32'(we_count - we0), (rd != 4'd0) ? 32'd1 : 32'd0);
    check({tag, "_idle_we"}, 32'(bus.bankWriteEnable), 32'd0);
    check({tag, "_idle_wbr"}, 32'(bus.wbReady), 32'd1);
  endtask

  // Issue one operand read; checks per-cycle bank address, pulse timing and values
  task automatic do_read(input logic [3:0] a1, input logic [3:0] a2,
                         input logic [31:0] e1, input logic [31:0] e2, input string tag);
    int waited = 0;
    bus.readValid = 1'b1;
    bus.rs1       = a1;
    bus.rs2       = a2;
    while (!bus.readReady && waited < 20) begin
      tick();
      waited++;
    end
    check({tag, "_rdready"}, 32'(bus.readReady), 32'd1);
    accept_cyc = cyc;
    tick();
    bus.readValid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) tick();
      check({tag, "_ov"}, 32'(bus.operandsValid), (k == 4) ? 32'd1 : 32'd0);
      check({tag, "_addr"}, 32'(bus.bankRegNum),
            (k == 1) ? 32'(a1) : (k == 4) ? 32'd0 : 32'(a2));
    end
    check({tag, "_rs1v"}, bus.rs1Value, e1);
    check({tag, "_rs2v"}, bus.rs2Value, e2);
    tick();
    check({tag, "_ov_off"}, 32'(bus.operandsValid), 32'd0);
  endtask

  initial begin
    int we_before;
    int prev_accept;

    bus.readValid = 1'b0;
    bus.rs1       = 4'd0;
    bus.rs2       = 4'd0;
    bus.wbValid   = 1'b0;
    bus.wbReg     = 4'd0;
    bus.wbData    = 32'h0;

    // Reset held two cycles
    repeat (2) @(posedge clk);
    #1;
    check("rst_readReady", 32'(bus.readReady), 32'd1);
    check("rst_wbReady",   32'(bus.wbReady), 32'd1);
    check("rst_ov",        32'(bus.operandsValid), 32'd0);
    check("rst_rs1v",      bus.rs1Value, 32'h0);
    check("rst_rs2v",      bus.rs2Value, 32'h0);
    check("rst_regnum",    32'(bus.bankRegNum), 32'd0);
    check("rst_datain",    bus.bankDataIn, 32'h0);
    check("rst_we",        32'(bus.bankWriteEnable), 32'd0);
    reset     = 1'b0;
    bank_init = 1'b0;
    tick();

    // Write r5 then read r5/r0
    do_write(4'd5, 32'hDEAD_BEEF, "w5");
    do_read(4'd5, 4'd0, 32'hDEAD_BEEF, 32'h0, "r5_0");

    // Simultaneous requests: writeback first, read sees the new value
    bus.wbValid   = 1'b1;
    bus.wbReg     = 4'd3;
    bus.wbData    = 32'h1234_5678;
    bus.readValid = 1'b1;
    bus.rs1       = 4'd3;
    bus.rs2       = 4'd3;
    #1;
    check("sim_readReady", 32'(bus.readReady), 32'd0);
    check("sim_wbReady",   32'(bus.wbReady), 32'd1);
    tick();
    bus.wbValid = 1'b0;
    check("sim_wr_we",     32'(bus.bankWriteEnable), 32'd1);
    check("sim_wr_rdr",    32'(bus.readReady), 32'd0);
    tick();
    do_read(4'd3, 4'd3, 32'h1234_5678, 32'h1234_5678, "r3_3");

    // Write to x0 is discarded; x0 reads zero despite nonzero bank contents
    do_write(4'd0, 32'hFFFF_FFFF, "w0");
    do_read(4'd0, 4'd0, 32'h0, 32'h0, "r0_0");

    // Load nonzero operands, then reset during RD2 of the next read
    do_read(4'd3, 4'd5, 32'h1234_5678, 32'hDEAD_BEEF, "r3_5");
    bus.readValid = 1'b1;
    bus.rs1       = 4'd5;
    bus.rs2       = 4'd3;
    tick();
    bus.readValid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check("mid_ov",     32'(bus.operandsValid), 32'd0);
    check("mid_rs1v",   bus.rs1Value, 32'h0);
    check("mid_rs2v",   bus.rs2Value, 32'h0);
    check("mid_regnum", 32'(bus.bankRegNum), 32'd0);
    check("mid_rdr",    32'(bus.readReady), 32'd1);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("mid_no_pulse", 32'(bus.operandsValid), 32'd0);
    end
    do_read(4'd5, 4'd3, 32'hDEAD_BEEF, 32'h1234_5678, "post_rst");

    // Reset during WR suppresses the bank write
    bus.wbValid = 1'b1;
    bus.wbReg   = 4'd7;
    bus.wbData  = 32'h7777_7777;
    tick();
    bus.wbValid = 1'b0;
    check("wrst_we_pre", 32'(bus.bankWriteEnable), 32'd1);
    we_before = we_count;
    reset = 1'b1;
    #1;
    check("wrst_we_gated", 32'(bus.bankWriteEnable), 32'd0);
    tick();
    check("wrst_wecount", 32'(we_count - we_before), 32'd0);
    reset = 1'b0;
    tick();
    do_read(4'd7, 4'd0, 32'hA500_0007, 32'h0, "r7_keep");

    // Preload r1..r15, then back-to-back reads with fixed spacing
    for (int i = 1; i < 16; i++) do_write(4'(i), 32'h1000 + 32'(i), "pre");
    prev_accept = 0;
    for (int i = 1; i < 16; i++) begin
      do_read(4'(i), 4'(16 - i), 32'h1000 + 32'(i), 32'h1000 + 32'(16 - i), "b2b");
      if (i > 1) check("b2b_spacing", 32'(accept_cyc - prev_accept), 32'd5);
      prev_accept = accept_cyc;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
